// File: rtl/muldiv_issue_if.sv
// rtl/muldiv_issue_if.sv - request, unit and response signals of the mul/div issue controller
interface muldiv_issue_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_inst_i;
    logic [31:0] req_rs1_data_i;
    logic [31:0] req_rs2_data_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        busy_o;
    logic [7:0]  md_inst_o;
    logic [31:0] md_reg1_data_o;
    logic [31:0] md_reg2_data_o;
    logic [31:0] md_data_i;
    logic        md_ready_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_timeout_o;

    modport slave (
        input  req_valid_i, req_inst_i, req_rs1_data_i, req_rs2_data_i, req_rd_i,
        input  flush_i, md_data_i, md_ready_i, rsp_ready_i,
        output req_ready_o, busy_o, md_inst_o, md_reg1_data_o, md_reg2_data_o,
        output rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_timeout_o
    );

    modport master (
        output req_valid_i, req_inst_i, req_rs1_data_i, req_rs2_data_i, req_rd_i,
        output flush_i, md_data_i, md_ready_i, rsp_ready_i,
        input  req_ready_o, busy_o, md_inst_o, md_reg1_data_o, md_reg2_data_o,
        input  rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_timeout_o
    );
endinterface

// File: rtl/muldiv_issue.sv
// rtl/muldiv_issue.sv - issue/sequencing controller for the multi-cycle mul/div unit
module muldiv_issue #(
    parameter int TIMEOUT_CYC = 40,
    parameter int CNT_W       = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    muldiv_issue_if.slave bus
);
    localparam logic [7:0] INST_MUL    = 8'h01;
    localparam logic [7:0] INST_MULH   = 8'h02;
    localparam logic [7:0] INST_MULHSU = 8'h03;
    localparam logic [7:0] INST_MULHU  = 8'h04;
    localparam logic [7:0] INST_DIV    = 8'h05;
    localparam logic [7:0] INST_DIVU   = 8'h06;
    localparam logic [7:0] INST_REM    = 8'h07;
    localparam logic [7:0] INST_REMU   = 8'h08;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       inst_q;
    logic [31:0]      op1_q;
    logic [31:0]      op2_q;
    logic [31:0]      data_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             is_m;
    logic             accept;
    logic             run_timeout;
    logic             in_run;

    assign is_m = bus.req_inst_i inside {INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU,
                                         INST_DIV, INST_DIVU, INST_REM, INST_REMU};

    assign bus.req_ready_o = (state_q == S_IDLE) && !bus.flush_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign run_timeout     = (cnt_q == CNT_LAST);
    assign in_run          = (state_q == S_RUN);

    // Outside RUN the unit sees opcode 0, which re-arms its iteration counter.
    assign bus.md_inst_o      = in_run ? inst_q : 8'h00;
    assign bus.md_reg1_data_o = in_run ? op1_q : 32'h0;
    assign bus.md_reg2_data_o = in_run ? op2_q : 32'h0;

    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.rsp_valid_o   = (state_q == S_HOLD);
    assign bus.rsp_data_o    = data_q;
    assign bus.rsp_rd_o      = rd_q;
    assign bus.rsp_timeout_o = timeout_q;

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept && is_m) state_d = S_RUN;
                S_RUN:   if (bus.md_ready_i || run_timeout) state_d = S_HOLD;
                S_HOLD:  if (bus.rsp_ready_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inst_q    <= 8'h00;
            op1_q     <= 32'h0;
            op2_q     <= 32'h0;
            rd_q      <= 5'h0;
            data_q    <= 32'h0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && is_m) begin
                        inst_q    <= bus.req_inst_i;
                        op1_q     <= bus.req_rs1_data_i;
                        op2_q     <= bus.req_rs2_data_i;
                        rd_q      <= bus.req_rd_i;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Unit result wins over the watchdog when both land in the same cycle.
                    if (!bus.flush_i) begin
                        if (bus.md_ready_i) begin
                            data_q <= bus.md_data_i;
                        end else if (run_timeout) begin
                            data_q    <= 32'h0;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_issue.sv
// tb/tb_muldiv_issue.sv - scoreboard bench for muldiv_issue with a behavioural mul/div unit
module tb_muldiv_issue;
    localparam logic [7:0] C_MUL    = 8'h01;
    localparam logic [7:0] C_MULH   = 8'h02;
    localparam logic [7:0] C_MULHSU = 8'h03;
    localparam logic [7:0] C_MULHU  = 8'h04;
    localparam logic [7:0] C_DIV    = 8'h05;
    localparam logic [7:0] C_DIVU   = 8'h06;
    localparam logic [7:0] C_REM    = 8'h07;
    localparam logic [7:0] C_REMU   = 8'h08;
    localparam int LAT_UNIT = 35;
    localparam int LAT_TO   = 41;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        to;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stub = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic [5:0] ucyc;

    muldiv_issue_if bus();

    muldiv_issue #(.TIMEOUT_CYC(40), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic is_mcode(input logic [7:0] op);
        logic [7:0] codes [8] = '{C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU};
        foreach (codes[i]) if (codes[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_md(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        longint          p;
        longint unsigned pu;
        case (op)
            C_MUL:    begin pu = ua * ub; return pu[31:0]; end
            C_MULH:   begin p = sa * sb; return p[63:32]; end
            C_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            C_MULHU:  begin pu = ua * ub; return pu[63:32]; end
            C_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(int'(a) / int'(b));
            end
            C_DIVU:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            C_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(int'(a) % int'(b));
            end
            C_REMU:   return (b == 32'h0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    // Unit model: ready in its 34th consecutive cycle of seeing a valid opcode.
    always @(posedge clk) begin
        if (rst || !is_mcode(bus.md_inst_o)) ucyc <= 6'd0;
        else if (ucyc != 6'd63) ucyc <= ucyc + 6'd1;
    end
    assign bus.md_ready_i = !stub && is_mcode(bus.md_inst_o) && (ucyc == 6'd33);
    assign bus.md_data_i  = bus.md_ready_i ? ref_md(bus.md_inst_o, bus.md_reg1_data_o, bus.md_reg2_data_o)
                                           : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_md_inst"}, 32'(bus.md_inst_o), 32'd0);
        chk({tag, "_md_reg1"}, bus.md_reg1_data_o, 32'd0);
        chk({tag, "_md_reg2"}, bus.md_reg2_data_o, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        chk({tag, "_rsp_data"}, bus.rsp_data_o, 32'd0);
        chk({tag, "_rsp_rd"}, 32'(bus.rsp_rd_o), 32'd0);
        chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout_o), 32'd0);
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int acc);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_inst_i     = op;
        bus.req_rs1_data_i = a;
        bus.req_rs2_data_i = b;
        bus.req_rd_i       = rd;
        #1;
        while (!bus.req_ready_o && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        acc = cyc;
        if (!bus.req_ready_o) begin
            chk("issue_accept_timeout", 32'(bus.req_ready_o), 32'd1);
        end else begin
            chk("rearm_at_accept", 32'(bus.md_inst_o), 32'd0);
            if (is_mcode(op)) begin
                e.data = stub ? 32'h0 : ref_md(op, a, b);
                e.rd   = rd;
                e.to   = stub;
                e.acc  = acc;
                e.lat  = stub ? LAT_TO : LAT_UNIT;
                q.push_back(e);
            end
        end
        @(negedge clk);
        bus.req_valid_i    = 1'b0;
        bus.req_inst_i     = 8'($urandom);
        bus.req_rs1_data_i = $urandom;
        bus.req_rs2_data_i = $urandom;
        bus.req_rd_i       = 5'($urandom);
        #1;
        if (is_mcode(op)) begin
            chk("md_inst_run", 32'(bus.md_inst_o), 32'(op));
            chk("md_reg1_run", bus.md_reg1_data_o, a);
            chk("md_reg2_run", bus.md_reg2_data_o, b);
        end else begin
            chk("drop_busy", 32'(bus.busy_o), 32'd0);
        end
    endtask

    task automatic wait_drain(input logic bp);
        int n = 0;
        while (n < 2000) begin
            @(negedge clk);
            bus.rsp_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (q.size() == 0 && !bus.busy_o) break;
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.rsp_valid_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.rsp_valid_o) chk("wait_valid_timeout", 32'(bus.rsp_valid_o), 32'd1);
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (bus.rsp_valid_o && !prev) begin
                    if (q.size() == 0) chk("unexpected_rsp", 32'(bus.rsp_valid_o), 32'd0);
                    else chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                end
                if (bus.rsp_valid_o && bus.rsp_ready_i && q.size() != 0) begin
                    e = q.pop_front();
                    chk("rsp_data", bus.rsp_data_o, e.data);
                    chk("rsp_rd", 32'(bus.rsp_rd_o), 32'(e.rd));
                    chk("rsp_timeout", 32'(bus.rsp_timeout_o), 32'(e.to));
                end
                prev = bus.rsp_valid_o;
            end
        end
    end

    initial begin : watchdog
        #600000;
        errors++;
        $display("FAIL global_watchdog: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin : stim
        int acc;
        int bad;
        logic [7:0]  op;
        logic [31:0] a, b;
        logic [7:0] codes [8] = '{C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU};

        bus.req_valid_i = 1'b0;
        bus.req_inst_i = 8'h00;
        bus.req_rs1_data_i = 32'h0;
        bus.req_rs2_data_i = 32'h0;
        bus.req_rd_i = 5'h0;
        bus.flush_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("reset");

        issue(C_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, acc);
        bad = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            #1;
            if (!bus.busy_o) bad++;
        end
        chk("busy_throughout", 32'(bad), 32'd0);
        wait_drain(1'b0);

        issue(C_DIVU, 32'd100, 32'd7, 5'd1, acc);
        issue(C_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, acc);
        wait_drain(1'b0);

        bus.rsp_ready_i = 1'b0;
        issue(C_DIV, 32'd5, 32'd0, 5'd3, acc);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            chk("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
            chk("hold_data", bus.rsp_data_o, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_after_hold_busy", 32'(bus.busy_o), 32'd0);
        chk("idle_after_hold_valid", 32'(bus.rsp_valid_o), 32'd0);

        issue(C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, acc);
        goto_cycle(acc + 10);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        q.delete();
        #1;
        chk("flush_busy", 32'(bus.busy_o), 32'd0);
        chk("flush_md_inst", 32'(bus.md_inst_o), 32'd0);
        issue(C_MUL, 32'd3, 32'd4, 5'd6, acc);
        wait_drain(1'b0);

        @(negedge clk);
        bus.flush_i = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_inst_i = C_MUL;
        #1;
        chk("flush_blocks_req", 32'(bus.req_ready_o), 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        #1;
        chk("flush_req_dropped", 32'(bus.busy_o), 32'd0);

        stub = 1'b1;
        issue(C_DIVU, 32'd9, 32'd3, 5'd7, acc);
        wait_drain(1'b0);
        stub = 1'b0;

        issue(C_REMU, 32'd50, 32'd6, 5'd8, acc);
        goto_cycle(acc + 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        #1;
        chk_reset_outputs("rst_run");

        bus.rsp_ready_i = 1'b0;
        issue(C_MULH, 32'h8000_0000, 32'd3, 5'd9, acc);
        wait_valid();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        #1;
        chk_reset_outputs("rst_hold");
        bus.rsp_ready_i = 1'b1;

        issue(8'h00, 32'd1, 32'd2, 5'd10, acc);
        repeat (3) @(negedge clk);
        #1;
        chk("null_inst_busy", 32'(bus.busy_o), 32'd0);

        for (int i = 0; i < 24; i++) begin
            op = (i % 7 == 6) ? 8'h55 : codes[$urandom_range(0, 7)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            issue(op, a, b, 5'($urandom), acc);
            wait_drain(1'b1);
        end
        bus.rsp_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("queue_empty_end", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_issue.md
Name: muldiv_issue

Overview:
- Issue and sequencing controller on the execute-stage side of the multi-cycle mul/div unit. It is the requester end of that unit's interface.
- Accepts one M-extension request per handshake from the pipeline, holds the opcode and operands stable on the unit interface until the unit reports ready, then captures the result.
- Presents the result to writeback through a valid/ready handshake and re-arms the unit between operations.
- Provides the pipeline stall signal, flush abort and a hang watchdog.

Parameters:
TIMEOUT_CYC, 40, RUN cycles allowed before the op is abandoned with a timeout response (must be greater than 34).
CNT_W, 6, width of the RUN cycle counter (2^CNT_W must exceed TIMEOUT_CYC).

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  request accepted this cycle when valid&ready
req_inst_i  input  8  instruction code (`MUL..`REMU from inst_def.v)
req_rs1_data_i  input  32  operand 1
req_rs2_data_i  input  32  operand 2
req_rd_i  input  5  destination register
flush_i  input  1  abort any in-flight op
busy_o  output  1  pipeline stall, high whenever state != IDLE
md_inst_o  output  8  to unit inst_i
md_reg1_data_o  output  32  to unit reg1_data_i
md_reg2_data_o  output  32  to unit reg2_data_i
md_data_i  input  32  from unit data_o
md_ready_i  input  1  from unit ready_o
rsp_valid_o  output  1  result valid
rsp_ready_i  input  1  writeback accepts result
rsp_data_o  output  32  result
rsp_rd_o  output  5  destination register of result
rsp_timeout_o  output  1  result is a watchdog abort (data forced 0)

Behaviour:

States: IDLE, RUN, HOLD. State encoding is free.

Reset (rst_i=1 at edge, any state including mid-op):
- state=IDLE; inst_q, op1_q, op2_q, rd_q, data_q, cnt=0; timeout_q=0.
- Outputs after reset: req_ready_o=1 (if flush_i=0), busy_o=0, md_inst_o=8'h00, md_reg*_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_rd_o=0, rsp_timeout_o=0.

Combinational outputs:
- req_ready_o = (state==IDLE) & ~flush_i.
- md_inst_o = (state==RUN) ? inst_q : 8'h00. md_reg1/2_data_o = (state==RUN) ? op1_q/op2_q : 0.
- 8'h00 is not a mul/div code; driving it resets the unit's internal counter to its start value.
- rsp_valid_o = (state==HOLD). rsp_data_o/rsp_rd_o/rsp_timeout_o come from data_q/rd_q/timeout_q.

IDLE:
- On req_valid_i & req_ready_o with req_inst_i one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: latch inst/operands/rd, cnt=0, timeout_q=0, go to RUN.
- A non-M code is consumed (ready high) and dropped: no response, stay IDLE.

RUN:
- cnt increments each cycle, saturating at TIMEOUT_CYC.
- If md_ready_i=1: data_q<=md_data_i in the same cycle, while md_inst_o is still valid. Go to HOLD.
- Else if cnt==TIMEOUT_CYC-1: data_q<=0, timeout_q<=1, go to HOLD.
- md_ready_i takes priority over timeout in the same cycle.
- With the current unit, md_ready_i rises in the 34th RUN cycle (1 start + 32 iterations + ready), so the response becomes visible 35 cycles after acceptance.

HOLD:
- md_inst_o=0, which guarantees at least one re-arm cycle for the unit.
- Hold data stable until rsp_ready_i=1, then go to IDLE. A new request can be accepted in the following IDLE cycle.

flush_i=1 (any state):
- Next state IDLE; rsp_valid_o drops next cycle. An unhandshaked HOLD result is discarded.
- Flush takes priority over md_ready_i, timeout and rsp handshake.
- A request presented in the flush cycle is not accepted.
- The first IDLE cycle after a flush drives md_inst_o=0, so the unit is re-armed before any new RUN.

Arithmetic and edge cases:
- Results, including divide-by-zero and overflow, are passed through from the unit unmodified.
- Operands are held constant for the whole of RUN regardless of req_* changes.

Test Plan:
- With the real muldiv unit: MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> rsp_valid_o rises 35 cycles after accept, rsp_data_o=0xFFFFFFEB, rsp_rd_o=5, rsp_timeout_o=0, busy_o high throughout.
- DIVU 100/7 then REM 0xFFFFFFF9 % 2 issued back-to-back, rsp_ready_i=1 -> results 14 and 0xFFFFFFFF; md_inst_o=0 for at least one cycle between the two RUN periods.
- DIV 5/0 with rsp_ready_i held 0 for 10 cycles -> rsp_valid_o and rsp_data_o=0xFFFFFFFF stable all 10 cycles; IDLE the cycle after rsp_ready_i=1.
- MULHU 0xFFFFFFFF*0xFFFFFFFF, flush_i pulsed in RUN cycle 10 -> no response, IDLE next cycle; a following MUL 3*4 returns 12 with normal latency.
- Stub unit with md_ready_i tied 0, TIMEOUT_CYC=40 -> response after 40 RUN cycles with rsp_data_o=0, rsp_timeout_o=1.
- rst_i asserted in RUN cycle 5, and separately in HOLD -> all outputs at reset values next cycle; req_inst_i=8'h00 with valid -> accepted, no response, busy_o stays 0.
